alu_operand_loader: RTL and testbench
=====================================

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable synchronized samples before a key level is accepted.
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 sw  input  17  raw switch value; operand and opcode source.
REQ-005 key_load_n  input  1  raw push-button, active-low, asynchronous to CLK.
REQ-006 key_clear_n  input  1  raw push-button, active-low, asynchronous to CLK.
REQ-007 portA  output  32  captured operand A (word_t).
REQ-008 portB  output  32  captured operand B (word_t).
REQ-009 aluop  output  4  captured opcode (aluop_t).
REQ-010 out_valid  output  1  operand set complete, held for the downstream ALU.
REQ-011 out_ready  input  1  downstream consumed the operand set.
REQ-012 state_leds  output  4  one-hot state display, bit order LOAD_A, LOAD_B, LOAD_OP, PRESENT.

Function
REQ-013 Each key SHALL pass a 2-flop synchronizer before any use.
REQ-014 Debouncer SHALL per key count cycles where the synchronized level differs from the accepted level, reset the count on any match, and flip the accepted level when the count reaches DEBOUNCE_CYCLES.
REQ-015 A press event SHALL be a one-cycle pulse on the accepted-level released-to-pressed transition; the release SHALL generate no event.
REQ-016 FSM states SHALL be LOAD_A, LOAD_B, LOAD_OP and PRESENT.
REQ-017 LOAD_A + load event: capture sw into portA; go to LOAD_B.
REQ-018 LOAD_B + load event: capture sw into portB; go to LOAD_OP.
REQ-019 LOAD_OP + load event: capture sw[3:0] into aluop; go to PRESENT.
REQ-020 out_valid SHALL be 1 exactly while in PRESENT, starting the cycle after the LOAD_OP capture.
REQ-021 In PRESENT, out_valid=1 and out_ready=1 in the same cycle SHALL complete the handshake; the next state SHALL be LOAD_A, with portA/portB/aluop held at their values.
REQ-022 portA, portB and aluop SHALL NOT change while out_valid=1; load events in PRESENT SHALL be ignored.
REQ-023 A clear event in any state SHALL go to LOAD_A and zero portA, portB and aluop the next cycle; clear SHALL win over a simultaneous load event or handshake.
REQ-024 out_ready SHALL be ignored outside PRESENT.
REQ-025 Unused or illegal state encodings SHALL recover to LOAD_A on the next cycle.
REQ-026 state_leds SHALL equal the one-hot current state, registered.

Reset
REQ-027 On RST=1 at a CLK edge the block SHALL set state=LOAD_A, portA=0, portB=0, aluop=0, out_valid=0, state_leds=4'b0001.
REQ-028 On RST=1 at a CLK edge, debounce counters SHALL be 0, accepted levels SHALL be released (1), and synchronizers SHALL be 1.
REQ-029 Reset mid-sequence or during PRESENT SHALL discard the partial or pending set; no event SHALL be generated on reset exit.

Configuration
REQ-030 Macro ALU_OPERAND_LOADER_SIGNEXT_EN, when defined, SHALL sign-extend sw[16] into portA/portB bits 31:17; when undefined, bits 31:17 SHALL be zero.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Bench SHALL cover: key_load_n low for 3 cycles then high -> no capture, state stays LOAD_A.
REQ-032 Bench SHALL cover: loads with sw=17'h00005, 17'h00003, then 4'h3 -> portA=5, portB=3, aluop=3, out_valid=1, state_leds=1000.
REQ-033 Bench SHALL cover: in PRESENT, out_ready=0 for 10 cycles plus an extra load press, then out_ready=1 -> outputs stable throughout, out_valid drops next cycle, state_leds=0001.
REQ-034 Bench SHALL cover: clear press coinciding with the load event in LOAD_OP -> state LOAD_A, all outputs 0, out_valid never asserted.
REQ-035 Bench SHALL cover: sw=17'h1FFFF loaded as A -> portA=32'hFFFFFFFF with the macro defined, 32'h0001FFFF without it.
REQ-036 Bench SHALL cover: RST pulsed while in LOAD_B with key held pressed -> reset values, and no event until release plus a new press.

Source files
------------

// File: rtl/alu_operand_loader.sv
// ============================================================================
// alu_operand_loader: debounced key-driven capture of ALU operands A, B and op.
// Optional: define ALU_OPERAND_LOADER_SIGNEXT_EN to sign-extend sw[16].
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [16:0] sw,
    input  logic        key_load_n,
    input  logic        key_clear_n,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output logic [3:0]  aluop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  state_leds
);

    typedef logic [31:0] word_t;
    typedef logic [3:0]  aluop_t;

    typedef enum logic [3:0] {
        LOAD_A  = 4'b0001,
        LOAD_B  = 4'b0010,
        LOAD_OP = 4'b0100,
        PRESENT = 4'b1000
    } state_t;

    localparam int c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int c_KEY_LOAD  = 0;
    localparam int c_KEY_CLEAR = 1;

    logic [1:0] w_key_raw;
    logic [1:0] w_evt;
    logic [1:0] r_flush;
    logic       w_flushed;
    logic       w_load_evt;
    logic       w_clear_evt;
    word_t      w_sw_word;

    assign w_key_raw   = {key_clear_n, key_load_n};
    assign w_flushed   = (r_flush == 2'd2);
    assign w_load_evt  = w_evt[c_KEY_LOAD];
    assign w_clear_evt = w_evt[c_KEY_CLEAR];

`ifdef ALU_OPERAND_LOADER_SIGNEXT_EN
    assign w_sw_word = {{15{sw[16]}}, sw};
`else
    assign w_sw_word = {15'b0, sw};
`endif

    // Synchronizer output is only trustworthy once its reset value has flushed out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_flush <= 2'd0;
        end else if (!w_flushed) begin
            r_flush <= r_flush + 2'd1;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic [1:0]         r_sync;
        logic               r_level;
        logic               r_armed;
        logic               r_evt;
        logic [c_CNT_W-1:0] r_cnt;

        // A key held through reset must be released before it may fire again,
        // so events stay disarmed until a genuine released level is seen.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_sync  <= 2'b11;
                r_level <= 1'b1;
                r_armed <= 1'b0;
                r_evt   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync <= {r_sync[0], w_key_raw[k]};
                r_evt  <= 1'b0;
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync[1];
                    r_evt   <= r_level & r_armed;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_flushed && r_level && r_sync[1]) begin
                    r_armed <= 1'b1;
                end
            end
        end

        assign w_evt[k] = r_evt;
    end

    state_t r_state;
    state_t w_state_next;
    logic   w_cap_a;
    logic   w_cap_b;
    logic   w_cap_op;
    logic   w_zero;
    word_t  r_port_a;
    word_t  r_port_b;
    aluop_t r_aluop;
    logic   r_out_valid;
    logic [3:0] r_state_leds;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= LOAD_A;
            r_out_valid  <= 1'b0;
            r_state_leds <= LOAD_A;
        end else begin
            r_state      <= w_state_next;
            r_out_valid  <= (w_state_next == PRESENT);
            r_state_leds <= w_state_next;
        end
    end

    // Clear outranks both a load event and a handshake in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_cap_a      = 1'b0;
        w_cap_b      = 1'b0;
        w_cap_op     = 1'b0;
        w_zero       = 1'b0;
        if (w_clear_evt) begin
            w_state_next = LOAD_A;
            w_zero       = 1'b1;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_load_evt) begin
                        w_cap_a      = 1'b1;
                        w_state_next = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_load_evt) begin
                        w_cap_b      = 1'b1;
                        w_state_next = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (w_load_evt) begin
                        w_cap_op     = 1'b1;
                        w_state_next = PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        w_state_next = LOAD_A;
                    end
                end
                default: begin
                    w_state_next = LOAD_A;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || w_zero) begin
            r_port_a <= '0;
            r_port_b <= '0;
            r_aluop  <= '0;
        end else begin
            if (w_cap_a) begin
                r_port_a <= w_sw_word;
            end
            if (w_cap_b) begin
                r_port_b <= w_sw_word;
            end
            if (w_cap_op) begin
                r_aluop <= sw[3:0];
            end
        end
    end

    assign portA      = r_port_a;
    assign portB      = r_port_b;
    assign aluop      = r_aluop;
    assign out_valid  = r_out_valid;
    assign state_leds = r_state_leds;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ============================================================================
// tb_alu_operand_loader: directed and randomized checks against a
// transaction-level model of the operand loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [16:0] sw = '0;
    logic        key_load_n = 1'b1;
    logic        key_clear_n = 1'b1;
    logic [31:0] portA;
    logic [31:0] portB;
    logic [3:0]  aluop;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  state_leds;

    int n_cmp = 0;
    int n_err = 0;

    // Model: stage 0..3 = LOAD_A, LOAD_B, LOAD_OP, PRESENT
    int          m_st = 0;
    logic [31:0] m_a  = '0;
    logic [31:0] m_b  = '0;
    logic [3:0]  m_op = '0;

    logic watch = 1'b0;
    logic valid_seen = 1'b0;

    alu_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sw         (sw),
        .key_load_n (key_load_n),
        .key_clear_n(key_clear_n),
        .portA      (portA),
        .portB      (portB),
        .aluop      (aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_leds (state_leds)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (watch && out_valid) valid_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] ext(input logic [16:0] s);
        logic [31:0] v;
        v = 32'(s);
`ifdef ALU_OPERAND_LOADER_SIGNEXT_EN
        if (s[16]) v = v | 32'hFFFE_0000;
`endif
        return v;
    endfunction

    task automatic model_load(input logic [16:0] s);
        if (m_st == 0) begin m_a = ext(s); m_st = 1; end
        else if (m_st == 1) begin m_b = ext(s); m_st = 2; end
        else if (m_st == 2) begin m_op = s[3:0]; m_st = 3; end
    endtask

    task automatic model_clear();
        m_a = '0; m_b = '0; m_op = '0; m_st = 0;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] leds;
        leds = 4'(1 << m_st);
        check({tag, ".portA"}, portA, m_a);
        check({tag, ".portB"}, portB, m_b);
        check({tag, ".aluop"}, 32'(aluop), 32'(m_op));
        check({tag, ".valid"}, 32'(out_valid), 32'(m_st == 3));
        check({tag, ".leds"}, 32'(state_leds), 32'(leds));
    endtask

    // A full press: held well beyond the debounce window, then released.
    task automatic press(input logic do_load, input logic do_clear);
        if (do_load)  key_load_n = 1'b0;
        if (do_clear) key_clear_n = 1'b0;
        tick(12);
        key_load_n  = 1'b1;
        key_clear_n = 1'b1;
        tick(12);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        model_clear();
        tick(6);
    endtask

    initial begin
        logic [16:0] s;
        int act;
        int len;

        do_reset();
        check_all("reset");

        // Short glitch below the debounce window
        key_load_n = 1'b0;
        tick(3);
        key_load_n = 1'b1;
        tick(12);
        check_all("glitch3");

        sw = 17'h00005; press(1, 0); model_load(sw); check_all("loadA");
        sw = 17'h00003; press(1, 0); model_load(sw); check_all("loadB");
        sw = 17'h00003; press(1, 0); model_load(sw); check_all("loadOP");

        // Held in PRESENT with out_ready low; extra load press ignored
        sw = 17'h1ABCD;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_all("hold");
        end
        press(1, 0);
        check_all("extra_load");
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        m_st = 0;
        check_all("handshake");

        // Clear coinciding with load event in LOAD_OP
        sw = 17'(($urandom)); press(1, 0); model_load(sw);
        sw = 17'(($urandom)); press(1, 0); model_load(sw);
        check_all("pre_clear");
        valid_seen = 1'b0;
        watch = 1'b1;
        press(1, 1);
        watch = 1'b0;
        model_clear();
        check_all("clear_wins");
        check("clear_no_valid", 32'(valid_seen), 32'd0);

        // All-ones switch value into A
        sw = 17'h1FFFF; press(1, 0); model_load(sw);
`ifdef ALU_OPERAND_LOADER_SIGNEXT_EN
        check("signext_A", portA, 32'hFFFF_FFFF);
`else
        check("zeroext_A", portA, 32'h0001_FFFF);
`endif
        press(0, 1); model_clear(); check_all("clear_after_ext");

        // Reset in LOAD_B while the load key is held down
        sw = 17'(($urandom)); press(1, 0); model_load(sw);
        check_all("in_loadB");
        key_load_n = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        model_clear();
        tick(1);
        check_all("reset_held");
        tick(20);
        check_all("held_no_event");
        key_load_n = 1'b1;
        tick(12);
        check_all("released_no_event");
        sw = 17'(($urandom)); press(1, 0); model_load(sw);
        check_all("new_press");

        // Randomized action sequence
        for (int i = 0; i < 40; i++) begin
            s = 17'($urandom);
            sw = s;
            act = int'($urandom_range(0, 5));
            case (act)
                0, 1, 2: begin
                    press(1, 0);
                    model_load(s);
                end
                3: begin
                    press(0, 1);
                    model_clear();
                end
                4: begin
                    out_ready = 1'b1;
                    tick(1);
                    out_ready = 1'b0;
                    if (m_st == 3) m_st = 0;
                    tick(1);
                end
                default: begin
                    len = int'($urandom_range(1, 3));
                    if ($urandom_range(0, 1) == 0) key_load_n = 1'b0;
                    else key_clear_n = 1'b0;
                    tick(len);
                    key_load_n  = 1'b1;
                    key_clear_n = 1'b1;
                    tick(8);
                end
            endcase
            sw = 17'($urandom);
            tick(1);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
